// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter plus output register that shares one valid/ready channel among
// four requesters; priority moves to the requester just after the last one accepted.
module mux_4to1_rr_arbiter #(
    parameter int WIDTH     = 64,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     data0,
    input  logic [WIDTH-1:0]     data1,
    input  logic [WIDTH-1:0]     data2,
    input  logic [WIDTH-1:0]     data3,
    input  logic [3:0]           in_valid,
    output logic [3:0]           in_ready,
    input  logic [3:0]           req_mask,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int NUM_REQ = 4;

    logic [WIDTH-1:0]     data_arr [NUM_REQ];
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0] out_src_q, out_src_d;

    logic                 load_en;
    logic                 any_req;
    logic [3:0]           req;
    logic [3:0]           gnt;
    logic [SEL_WIDTH-1:0] gnt_idx;

    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign data_arr[2] = data2;
    assign data_arr[3] = data3;

    assign load_en = !out_valid_q || out_ready;
    assign req     = in_valid & req_mask;

    // Walk from the farthest slot back toward rr_ptr so the nearest requester wins.
    always_comb begin : grant_search
        logic [SEL_WIDTH-1:0] idx;
        idx     = '0;
        any_req = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = rr_ptr_q + SEL_WIDTH'(k);
            if (req[idx]) begin
                any_req = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        gnt = 4'b0000;
        if (any_req) begin
            gnt = 4'b0001 << gnt_idx;
        end
    end

    assign in_ready = load_en ? gnt : 4'b0000;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            if (any_req) begin
                out_valid_d = 1'b1;
                out_data_d  = data_arr[gnt_idx];
                out_src_d   = gnt_idx;
                rr_ptr_d    = gnt_idx + SEL_WIDTH'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

    // Protocol monitors: remember what must still be on the wires at the next edge.
    logic [3:0]           pend_q, pend_d;
    logic                 hold_q, hold_d;
    logic [WIDTH-1:0]     pend_data_q [NUM_REQ];
    logic [WIDTH-1:0]     hold_data_q;
    logic [SEL_WIDTH-1:0] hold_src_q;

    always_comb begin
        pend_d = in_valid & ~in_ready;
        hold_d = out_valid_q && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            hold_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            hold_q <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_data_q <= out_data_q;
        hold_src_q  <= out_src_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            pend_data_q[k] <= data_arr[k];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_chk
            always @(posedge clk) begin
                if (rst_n && pend_q[gi]) begin
                    assert (in_valid[gi] && (data_arr[gi] == pend_data_q[gi]))
                    else $error("requester %0d changed its beat before acceptance", gi);
                end
            end
        end
    endgenerate

    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(in_ready))
            else $error("more than one in_ready bit high: %b", in_ready);
            if (hold_q) begin
                assert (out_valid_q && (out_data_q == hold_data_q) && (out_src_q == hold_src_q))
                else $error("output beat changed while stalled");
            end
        end
    end

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Self-checking bench: directed vector table and hand sequences, then random traffic
// compared against a distance-based round-robin reference model.
module tb_mux_4to1_rr_arbiter;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] tb_data [4];
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   req_mask;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_4to1_rr_arbiter #(.WIDTH(W), .SEL_WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data0     (tb_data[0]),
        .data1     (tb_data[1]),
        .data2     (tb_data[2]),
        .data3     (tb_data[3]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req_mask  (req_mask),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [3:0]  in_valid;
        logic [3:0]  req_mask;
        logic        out_ready;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_src;
        logic [63:0] exp_data;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the winner is the enabled requester at the smallest forward distance from ptr.
    function automatic int model_pick(input logic [3:0] v, input logic [3:0] m, input int ptr);
        int best  = -1;
        int bestd = 4;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && m[i] && (((i - ptr + 4) % 4) < bestd)) begin
                bestd = (i - ptr + 4) % 4;
                best  = i;
            end
        end
        return best;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        m_valid;
        logic [63:0] m_data;
        int          m_src;
        int          m_ptr;
        int          g;
        logic        le;
        logic [3:0]  acc;

        // Directed table, data_i = i+1; each row is one cycle, expectations are pre-edge values.
        tbl[0]  = '{4'b0011, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 64'd0};
        tbl[1]  = '{4'b0010, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 64'd1};
        tbl[2]  = '{4'b1111, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 64'd2};
        tbl[3]  = '{4'b1111, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 64'd3};
        tbl[4]  = '{4'b1111, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 64'd4};
        tbl[5]  = '{4'b1111, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 64'd1};
        tbl[6]  = '{4'b1111, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 64'd2};
        tbl[7]  = '{4'b1111, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 64'd3};
        tbl[8]  = '{4'b1111, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 64'd4};
        tbl[9]  = '{4'b1111, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 64'd1};
        tbl[10] = '{4'b1111, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 64'd1};
        tbl[11] = '{4'b1111, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 64'd1};
        tbl[12] = '{4'b1111, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd1, 64'd2};
        tbl[13] = '{4'b1111, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd3, 64'd4};
        tbl[14] = '{4'b1111, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd1, 64'd2};
        tbl[15] = '{4'b1111, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd3, 64'd4};
        tbl[16] = '{4'b1111, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 64'd2};
        tbl[17] = '{4'b1011, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 64'd3};
        tbl[18] = '{4'b0011, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 64'd4};
        tbl[19] = '{4'b0010, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 64'd1};
        tbl[20] = '{4'b0000, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd1, 64'd2};
        tbl[21] = '{4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 64'd0};

        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        req_mask  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tb_data[i] = 64'd0;

        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", out_data, 64'd0);
        check("reset out_src", 64'(out_src), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single requester 2 from reset.
        @(posedge clk); #1;
        in_valid   = 4'b0100;
        tb_data[2] = 64'hDEAD_BEEF_0000_0002;
        @(negedge clk);
        check("solo in_ready", 64'(in_ready), 64'b0100);
        check("solo pre out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 4'b0000;
        @(negedge clk);
        check("solo out_valid", 64'(out_valid), 64'd1);
        check("solo out_data", out_data, 64'hDEAD_BEEF_0000_0002);
        check("solo out_src", 64'(out_src), 64'd2);
        check("solo idle in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) tb_data[i] = 64'(i + 1);

        for (int r = 0; r < 22; r++) begin
            @(posedge clk); #1;
            in_valid  = tbl[r].in_valid;
            req_mask  = tbl[r].req_mask;
            out_ready = tbl[r].out_ready;
            @(negedge clk);
            $display("row %0d: in_valid=%b mask=%b out_ready=%b in_ready=%b out_valid=%b src=%0d data=%0h",
                     r, in_valid, req_mask, out_ready, in_ready, out_valid, out_src, out_data);
            check($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(tbl[r].exp_ready));
            check($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(tbl[r].exp_ov));
            if (tbl[r].exp_ov) begin
                check($sformatf("row%0d out_src", r), 64'(out_src), 64'(tbl[r].exp_src));
                check($sformatf("row%0d out_data", r), out_data, tbl[r].exp_data);
            end
        end

        // Load source 3, stall it, then pulse reset between clock edges.
        @(posedge clk); #1;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst-seq in_ready", 64'(in_ready), 64'b1000);
        @(posedge clk); #1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst-seq held valid", 64'(out_valid), 64'd1);
        check("rst-seq held src", 64'(out_src), 64'd3);
        check("rst-seq held data", out_data, 64'd4);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst out_data", out_data, 64'd0);
        check("async rst out_src", 64'(out_src), 64'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        @(negedge clk);
        check("post-rst first grant", 64'(in_ready), 64'b0010);
        check("post-rst out_valid", 64'(out_valid), 64'd0);

        // Random traffic from a fresh reset against the reference model.
        @(posedge clk); #1;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        req_mask  = 4'hF;
        out_ready = 1'b1;
        #2;
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_data  = 64'd0;
        m_src   = 0;
        m_ptr   = 0;
        acc     = 4'b0000;

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (!(in_valid[i] && !acc[i])) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    tb_data[i]  = {$urandom(), $urandom()};
                end
            end
            if ($urandom_range(0, 7) == 0) req_mask = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g   = model_pick(in_valid, req_mask, m_ptr);
            le  = !m_valid || out_ready;
            acc = (le && g >= 0) ? 4'(1 << g) : 4'b0000;
            check("rand in_ready", 64'(in_ready), 64'(acc));
            check("rand out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                check("rand out_src", 64'(out_src), 64'(m_src));
                check("rand out_data", out_data, m_data);
            end
            if (le) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = tb_data[g];
                    m_src   = g;
                    m_ptr   = (g + 1) % 4;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_4to1_rr_arbiter.md
Name: mux_4to1_rr_arbiter

Overview:
- Round-robin arbiter and output register in front of the 4:1 64-bit select datapath.
- Shares one output channel among four valid/ready requesters, one beat per transfer.
- Produces the one-hot select, registers the chosen data and source ID, and rotates priority after each accepted beat.
- Sits between four producer ports and a single downstream consumer.

Parameters:
- WIDTH, 64, data width of every channel.
- SEL_WIDTH, 2, width of source ID; fixed at 2 (four requesters).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data0..data3  input  WIDTH each  requester payloads.
- in_valid  input  4  bit i = requester i has a beat.
- in_ready  output  4  bit i = beat from requester i accepted this cycle.
- req_mask  input  4  bit i = 1 enables requester i; masked requesters are never granted.
- out_data  output  WIDTH  registered selected payload.
- out_src  output  SEL_WIDTH  registered ID of the source of out_data.
- out_valid  output  1  out_data/out_src hold a beat.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, rr_ptr=0. Mid-operation reset drops any held beat; no partial state survives.
- Internal state:
  - rr_ptr (2 bits): requester with highest priority.
  - Output register: out_valid, out_data, out_src.
- load_en = !out_valid | out_ready (register empty or draining this cycle).
- req[i] = in_valid[i] & req_mask[i].
- Grant (combinational, one-hot or zero): first i with req[i] set, searching rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, all mod 4.
- in_ready[i] = load_en & gnt[i]. At most one in_ready bit is high per cycle. in_ready never depends on in_valid of the same requester beyond the grant.
- On a clock edge with load_en and any req:
  - out_data <= data[g], out_src <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod 4. 3 wraps to 0.
- On a clock edge with load_en and no req: out_valid <= 0. out_data/out_src are held (don't-care) and rr_ptr is unchanged.
- On a clock edge with !load_en (out_valid=1, out_ready=0): everything is held. Grant is still computed but no in_ready is asserted.
- Timing and throughput:
  - Latency: beat accepted at edge N is visible on out_* after edge N.
  - Full throughput: one beat per cycle when out_ready is held high.
- Simultaneous drain and load: the output beat is consumed and the new beat is loaded on the same edge. No bubble.
- Fairness: with all four requesting continuously and out_ready=1, grants cycle 0,1,2,3,0,... No requester waits more than 3 accepted beats.
- req_mask changes take effect combinationally in the same cycle. Masking a requester that holds the grant but is not yet accepted simply moves the grant.
- Requester protocol (checked by assertion, not corrected):
  - A requester keeps in_valid and data stable until accepted.
  - Downstream sees out_data stable while out_valid & !out_ready.

Test Plan:
- Reset, then only in_valid=4'b0100, data2=64'hDEAD_BEEF_0000_0002, req_mask=4'hF, out_ready=1 -> in_ready=4'b0100 in cycle 0. Next cycle out_valid=1, out_data=64'hDEAD_BEEF_0000_0002, out_src=2, rr_ptr=3.
- All four valid continuously, out_ready=1, dataI=I+1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, with out_data 1,2,3,4,1,2.
- Backpressure: out_ready=0 after first load with in_valid=4'hF -> out_valid=1, out_data/out_src frozen at source 0, in_ready=4'b0000 for every stalled cycle. Raise out_ready -> same-edge drain and load of source 1.
- req_mask=4'b1010, in_valid=4'hF, out_ready=1 -> grants alternate 1,3,1,3. Sources 0 and 2 never get in_ready.
- Wrap: rr_ptr=3 (after granting 2), in_valid=4'b0011 -> grant 0, then rr_ptr=1 -> grant 1.
- Assert rst_n low for half a cycle while out_valid=1 and holding source 3 -> out_valid, out_data, out_src drop to 0 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-index requester per rr_ptr=0.
